frame_ram_arbiter: RTL
======================

Name: frame_ram_arbiter

Overview:
- Shares the single-port tile frame RAM (4800 x 3 bit, 80x60 grid of 8x8 tiles) between the video tile fetch and the game-logic writers (head draw, tail erase, food placement).
- Video reads own the RAM outside the write window. Writes are serialized round-robin inside the blanking-derived write window.
- A built-in clear sequencer wipes the whole frame on game restart.
- Sits between the snake game logic and the frame sram instance, on the pixel clock domain.

Parameters:
- NREQ, 3, number of write requesters.
- ADDR_W, 13, frame RAM address width.
- DATA_W, 3, tile/sprite index width.
- DEPTH, 4800, number of frame RAM entries swept by clear.
- CLEAR_VAL, 0, tile value written by clear (0 = empty tile).

Ports:
- clk  in  1  pixel clock; all logic on posedge.
- rstn  in  1  synchronous active-low reset.
- win  in  1  write window. 1 = video does not need RAM. Timing generator deasserts it at least 3 clk before the first active-video fetch.
- vid_addr  in  ADDR_W  video tile-fetch address.
- req  in  NREQ  per-requester write request; level, held until ack.
- wr_addr  in  NREQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W].
- wr_data  in  NREQ*DATA_W  packed tile values, same packing.
- ack  out  NREQ  one-cycle pulse in the cycle the requester's write is performed.
- old_data  out  DATA_W  previous tile content at the written address (see Optional Feature).
- clear_req  in  1  pulse: start full-frame clear.
- clear_busy  out  1  high while a clear is in progress.
- clear_done  out  1  one-cycle pulse after the last clear write.
- ram_addr  out  ADDR_W  to sram i_addr.
- ram_we  out  1  to sram i_write.
- ram_wdata  out  DATA_W  to sram i_data.
- ram_rdata  in  DATA_W  from sram o_data; 1-cycle read latency.

Behaviour:
- Reset (rstn=0 at posedge): state IDLE, rr pointer 0, clear counter 0. Outputs: ack=0, ram_we=0, clear_busy=0, clear_done=0, old_data=0. A clear or grant in flight is aborted: no ack, no done.
- RAM mux:
  - ram_we=0 except in WRITE and CLEAR-with-win.
  - ram_addr = vid_addr when state is IDLE or win=0. Otherwise it is the granted address or the clear counter.
  - ram_wdata drives the value being written; it is don't-care when ram_we=0.
- States: IDLE, WRITE, CLEAR (plus RD and RDW when FRAME_RMW_EN).
- IDLE:
  - If clear_req is pending, go to CLEAR. clear_req is latched into a pending flag, so a pulse arriving in any state is honored once.
  - Else, if win=1 and |req, latch grant index g, go to WRITE.
  - Else stay in IDLE.
  - Clear has priority over requesters.
- Round robin: g = first k with req[k]=1, searching from rr pointer upward with wrap mod NREQ. After a grant, rr pointer = (g+1) mod NREQ.
- WRITE (exactly 1 cycle, completes even if win falls):
  - ram_we=1, ram_addr=wr_addr[g], ram_wdata=wr_data[g], ack[g]=1.
  - Next state IDLE.
  - Throughput: 1 write per 2 clk.
  - Requesters must not change addr/data while req=1 and ack=0.
  - req deasserted before ack: the write still happens if already in WRITE. Otherwise it is not granted.
- CLEAR:
  - clear_busy=1. While win=1: ram_we=1, ram_addr=counter, ram_wdata=CLEAR_VAL, counter++.
  - While win=0: ram_we=0, counter holds, video has the RAM.
  - After the write to DEPTH-1: counter returns to 0, clear_done pulses next cycle, clear_busy falls with it, state IDLE.
  - No acks during CLEAR; requests wait.
  - A clear_req arriving during CLEAR is absorbed (no restart).
- Widths: counter ADDR_W bits, compared against DEPTH-1. No address beyond DEPTH-1 is ever written by clear.

Optional Feature:
- Macro FRAME_RMW_EN.
- Defined: each grant runs IDLE -> RD -> RDW -> WRITE.
  - RD: ram_addr=wr_addr[g], ram_we=0.
  - RDW: wait one cycle for sram latency, capture ram_rdata.
  - WRITE: old_data holds the captured value, valid in the ack cycle and held until the next ack. The head requester uses this for collision detection.
  - Throughput: 1 write per 4 clk.
  - If win falls in RD or RDW, the sequence still completes; the 3-clk guard covers it.
- Undefined: no RD/RDW states; old_data tied to 0.

Test Plan:
- Reset while in WRITE with req[1]=1 -> ram_we=0, ack=0 next cycle; state IDLE, rr=0.
- win=1, req=3'b111 held, addresses 100/200/300, data 1/2/3 -> acks in order 0,1,2 at 2-clk spacing (4 with FRAME_RMW_EN); RAM[100]=1, RAM[200]=2, RAM[300]=3.
- win=0, req[0]=1 -> no ram_we and ram_addr=vid_addr for 50 clk; set win=1 -> ack[0] within 2 clk (4 with RMW).
- clear_req pulse with win=1 -> 4800 consecutive writes of 0 to addresses 0..4799, then clear_done pulse; clear_busy high exactly during the sweep.
- clear with win toggling 100 clk on / 100 clk off -> counter holds while win=0, every address written exactly once, req[2] meanwhile gets ack only after clear_done.
- FRAME_RMW_EN: RAM[500]=4, req[0] writes 2 to 500 -> old_data=4 in the ack cycle, then RAM[500]=2.

Source files
------------

// File: rtl/frame_ram_arbiter.sv
// frame_ram_arbiter: shares the single-port tile frame RAM between the video
// tile fetch and NREQ game-logic writers. Writes are granted round-robin
// inside the write window. A clear sequencer can wipe the whole frame.
// Optional macro FRAME_RMW_EN: each grant first reads the old tile
// (IDLE -> RD -> RDW -> WRITE) and presents it on old_data in the ack cycle.
module frame_ram_arbiter #(
  parameter int NREQ      = 3,
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 3,
  parameter int DEPTH     = 4800,
  parameter int CLEAR_VAL = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     win,
  input  logic [ADDR_W-1:0]        vid_addr,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   wr_addr,
  input  logic [NREQ*DATA_W-1:0]   wr_data,
  output logic [NREQ-1:0]          ack,
  output logic [DATA_W-1:0]        old_data,
  input  logic                     clear_req,
  output logic                     clear_busy,
  output logic                     clear_done,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     ram_we,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] CLR_DATA  = DATA_W'(CLEAR_VAL);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_CLEAR, S_RD, S_RDW} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [IDX_W-1:0]  r_rr;
  logic [IDX_W-1:0]  r_g;
  logic [IDX_W-1:0]  w_g;
  logic [IDX_W-1:0]  w_rr_next;
  logic              w_any;
  logic              w_grant;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_clear_pend;
  logic              r_clear_done;
  logic              w_clear_pend;
  logic [ADDR_W-1:0] w_wr_addr [NREQ];
  logic [DATA_W-1:0] w_wr_data [NREQ];

  // Unpack the per-requester address/data buses.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_wr_addr[gi] = wr_addr[gi*ADDR_W +: ADDR_W];
    assign w_wr_data[gi] = wr_data[gi*DATA_W +: DATA_W];
  end

  // A clear request seen this cycle counts as pending immediately.
  assign w_clear_pend = r_clear_pend | clear_req;
  assign w_grant      = (r_state == S_IDLE) && !w_clear_pend && win && w_any;
  assign w_rr_next    = (w_g == IDX_W'(NREQ - 1)) ? '0 : w_g + 1'b1;
  assign clear_done   = r_clear_done;

  // Round-robin search: first requester at or above the pointer, wrapping.
  always_comb begin
    logic [IDX_W:0] sum;
    sum   = '0;
    w_g   = r_rr;
    w_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, r_rr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NREQ)) sum = sum - (IDX_W+1)'(NREQ);
      if (!w_any && req[sum[IDX_W-1:0]]) begin
        w_any = 1'b1;
        w_g   = sum[IDX_W-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and RAM mux; reset gates the strobes so an aborted grant never acks.
  always_comb begin
    w_state_next = r_state;
    ram_we       = 1'b0;
    ram_addr     = vid_addr;
    ram_wdata    = w_wr_data[r_g];
    ack          = '0;
    clear_busy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_clear_pend) begin
          w_state_next = S_CLEAR;
        end else if (win && w_any) begin
`ifdef FRAME_RMW_EN
          w_state_next = S_RD;
`else
          w_state_next = S_WRITE;
`endif
        end
      end
`ifdef FRAME_RMW_EN
      S_RD: begin
        ram_addr     = w_wr_addr[r_g];
        w_state_next = S_RDW;
      end
      S_RDW: begin
        w_state_next = S_WRITE;
      end
`endif
      S_WRITE: begin
        // The write completes even if the window has just closed.
        ram_we       = rstn;
        ram_addr     = w_wr_addr[r_g];
        ack[r_g]     = rstn;
        w_state_next = S_IDLE;
      end
      S_CLEAR: begin
        clear_busy = 1'b1;
        if (win) begin
          ram_we    = rstn;
          ram_addr  = r_clr_cnt;
          ram_wdata = CLR_DATA;
          if (r_clr_cnt == LAST_ADDR) w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Grant latch, round-robin pointer, clear counter and clear handshake.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rr         <= '0;
      r_g          <= '0;
      r_clr_cnt    <= '0;
      r_clear_pend <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_clear_done <= (r_state == S_CLEAR) && win && (r_clr_cnt == LAST_ADDR);
      if (r_state == S_CLEAR || (r_state == S_IDLE && w_clear_pend))
        r_clear_pend <= 1'b0;
      else if (clear_req)
        r_clear_pend <= 1'b1;
      if (w_grant) begin
        r_g  <= w_g;
        r_rr <= w_rr_next;
      end
      if (r_state == S_CLEAR && win)
        r_clr_cnt <= (r_clr_cnt == LAST_ADDR) ? '0 : r_clr_cnt + 1'b1;
    end
  end

`ifdef FRAME_RMW_EN
  logic [DATA_W-1:0] r_old_data;

  // Capture the old tile once the RAM read latency has elapsed.
  always_ff @(posedge clk) begin
    if (!rstn)                 r_old_data <= '0;
    else if (r_state == S_RDW) r_old_data <= ram_rdata;
  end

  assign old_data = r_old_data;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^ram_rdata;
  assign old_data       = '0;
`endif

endmodule
